// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode-side outputs,
// and the stall/redirect controls that decode and execute feed back.
// Handshake: decode takes inst/inst_pc/pc_plus4 on any rising edge where
// inst_valid = 1 and stall = 0. stall = 1 freezes the stage. redirect
// takes priority over stall and flushes the word that is in flight.
interface fetch_unit_if;
   logic [31:0] imem_a;
   logic [31:0] imem_rd;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] pc_plus4;
   logic        misalign_fault;
   logic [31:0] fetch_count;

   // The fetch unit drives the memory address and the decode-side outputs.
   modport master (
      output imem_a, inst_valid, inst, inst_pc, pc_plus4, misalign_fault, fetch_count,
      input  imem_rd, stall, redirect, redirect_pc
   );

   // Memory, decode and execute (or a testbench) sit on this side.
   modport slave (
      input  imem_a, inst_valid, inst, inst_pc, pc_plus4, misalign_fault, fetch_count,
      output imem_rd, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage. Holds the PC, presents it to a combinational
// instruction memory, and registers the returned word with its PC and PC+4.
// IDLE gives one settle cycle after reset. RUN fetches, stalls or redirects.
// FAULT is entered on a misaligned redirect target and only reset leaves it.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus,
   output logic [1:0]   state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        fault_q, fault_d;
   logic [31:0] count_q, count_d;
   logic        target_misaligned;

   assign target_misaligned = (bus.redirect_pc[1:0] != 2'b00);

   // Next-state logic. In RUN, redirect beats stall, and stall beats advance.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      pc_plus4_d   = pc_plus4_q;
      fault_d      = fault_q;
      count_d      = count_q;
      case (state_q)
         S_IDLE: begin
            inst_valid_d = 1'b0;
            state_d      = S_RUN;
            if (bus.redirect) begin
               pc_d = bus.redirect_pc;
               if (target_misaligned) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (bus.redirect) begin
               // The word fetched this cycle is on the wrong path, so drop it.
               pc_d         = bus.redirect_pc;
               inst_valid_d = 1'b0;
               if (target_misaligned) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
               end
            end else if (!bus.stall) begin
               inst_d       = bus.imem_rd;
               inst_pc_d    = pc_q;
               pc_plus4_d   = pc_q + 32'd4;
               inst_valid_d = 1'b1;
               pc_d         = pc_q + 32'd4;
               count_d      = count_q + 32'd1;
            end
         end
         S_FAULT: begin
            inst_valid_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers, with a synchronous reset that wins in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_q       <= NOP;
         inst_pc_q    <= 32'd0;
         pc_plus4_q   <= 32'd0;
         fault_q      <= 1'b0;
         count_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         pc_plus4_q   <= pc_plus4_d;
         fault_q      <= fault_d;
         count_q      <= count_d;
      end
   end

   assign bus.imem_a         = pc_q;
   assign bus.inst_valid     = inst_valid_q;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.pc_plus4       = pc_plus4_q;
   assign bus.misalign_fault = fault_q;
   assign bus.fetch_count    = count_q;
   assign state_o            = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table of per-edge stimulus and expected outputs,
// checked through an expected-value queue. Two instances: RESET_PC = 0 for
// the main sequence and RESET_PC = 0xFFFFFFFC for the address-wrap case.
module tb_fetch_unit;

   localparam int W = 164;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   logic       clk;
   logic       rst;
   logic       wrst;
   logic [1:0] state;
   logic [1:0] wstate;

   fetch_unit_if bus ();
   fetch_unit_if wbus ();

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(rst), .bus(bus), .state_o(state)
   );
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) wdut (
      .clk(clk), .reset(wrst), .bus(wbus), .state_o(wstate)
   );

   // Memory image: the word at index k holds 0xF shifted left by 4*(k mod 8).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] base;
      base = 32'h0000_000F;
      return base << {a[4:2], 2'b00};
   endfunction

   assign bus.imem_rd  = mem_word(bus.imem_a);
   assign wbus.imem_rd = mem_word(wbus.imem_a);

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] a;
      logic        v;
      logic [31:0] inst;
      logic [31:0] ipc;
      logic [31:0] p4;
      logic        f;
      logic [31:0] cnt;
      logic [1:0]  st;
   } vec_t;

   function automatic vec_t mk(
      input logic rs, input logic sl, input logic rd, input logic [31:0] rpc,
      input logic [31:0] a, input logic v, input logic [31:0] inst,
      input logic [31:0] ipc, input logic [31:0] p4, input logic f,
      input logic [31:0] cnt, input logic [1:0] st);
      vec_t r;
      r.rst = rs; r.stall = sl; r.redir = rd; r.rpc = rpc;
      r.a = a; r.v = v; r.inst = inst; r.ipc = ipc; r.p4 = p4;
      r.f = f; r.cnt = cnt; r.st = st;
      return r;
   endfunction

   vec_t          vecs[$];
   vec_t          wvecs[$];
   logic [W-1:0]  exp_q[$];
   int            n_checks = 0;
   int            n_err    = 0;

   task automatic chk(input string name, input int row,
                      input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp_v);
      end
   endtask

   // driver + scoreboard: drive one row, push its expectation, pop and compare after the edge
   task automatic run_vec(input vec_t v, input bit wrap_dut, input int row);
      logic [W-1:0] e;
      logic [31:0]  a, inst, ipc, p4, cnt;
      logic         vl, f;
      logic [1:0]   st;
      @(negedge clk);
      if (wrap_dut) begin
         wrst = v.rst; wbus.stall = v.stall; wbus.redirect = v.redir; wbus.redirect_pc = v.rpc;
      end else begin
         rst = v.rst; bus.stall = v.stall; bus.redirect = v.redir; bus.redirect_pc = v.rpc;
      end
      exp_q.push_back({v.a, v.v, v.inst, v.ipc, v.p4, v.f, v.cnt, v.st});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL row %0d queue: got empty expected entry", row);
      end else begin
         e = exp_q.pop_front();
         if (wrap_dut) begin
            a = wbus.imem_a; vl = wbus.inst_valid; inst = wbus.inst; ipc = wbus.inst_pc;
            p4 = wbus.pc_plus4; f = wbus.misalign_fault; cnt = wbus.fetch_count; st = wstate;
         end else begin
            a = bus.imem_a; vl = bus.inst_valid; inst = bus.inst; ipc = bus.inst_pc;
            p4 = bus.pc_plus4; f = bus.misalign_fault; cnt = bus.fetch_count; st = state;
         end
         chk("imem_a",         row, a,              e[163:132]);
         chk("inst_valid",     row, {31'd0, vl},    {31'd0, e[131]});
         chk("inst",           row, inst,           e[130:99]);
         chk("inst_pc",        row, ipc,            e[98:67]);
         chk("pc_plus4",       row, p4,             e[66:35]);
         chk("misalign_fault", row, {31'd0, f},     {31'd0, e[34]});
         chk("fetch_count",    row, cnt,            e[33:2]);
         chk("state",          row, {30'd0, st},    {30'd0, e[1:0]});
      end
   endtask

   initial begin
      rst = 1'b1; wrst = 1'b1;
      bus.stall = 1'b0;  bus.redirect = 1'b0;  bus.redirect_pc = 32'd0;
      wbus.stall = 1'b0; wbus.redirect = 1'b0; wbus.redirect_pc = 32'd0;

      //                 rst  stl  rdr  rpc          imem_a       v    inst          inst_pc      pc_plus4     f    cnt    state
      // boot
      vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,       32'h0,       1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_IDLE));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h4,       1'b1,32'h0000000F,32'h0,       32'h4,       1'b0,32'd1,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h8,       1'b1,32'h000000F0,32'h4,       32'h8,       1'b0,32'd2,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'hC,       1'b1,32'h00000F00,32'h8,       32'hC,       1'b0,32'd3,ST_RUN));
      // three stall cycles, then release
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,    32'hC,       1'b1,32'h00000F00,32'h8,       32'hC,       1'b0,32'd3,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h10,      1'b1,32'h0000F000,32'hC,       32'h10,      1'b0,32'd4,ST_RUN));
      // redirect together with stall, then target delivered
      vecs.push_back(mk(1'b0,1'b1,1'b1,32'h10,      32'h10,      1'b0,32'h0000F000,32'hC,       32'h10,      1'b0,32'd4,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h14,      1'b1,32'h000F0000,32'h10,      32'h14,      1'b0,32'd5,ST_RUN));
      // plain redirect to a new target
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h1C,      32'h1C,      1'b0,32'h000F0000,32'h10,      32'h14,      1'b0,32'd5,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h20,      1'b1,32'hF0000000,32'h1C,      32'h20,      1'b0,32'd6,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h24,      1'b1,32'h0000000F,32'h20,      32'h24,      1'b0,32'd7,ST_RUN));
      // reset during stall with inst_valid high
      vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,       32'h0,       1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_IDLE));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h0,       1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h4,       1'b1,32'h0000000F,32'h0,       32'h4,       1'b0,32'd1,ST_RUN));
      // misaligned redirect, then redirect/stall ignored in FAULT
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h6,       32'h6,       1'b0,32'h0000000F,32'h0,       32'h4,       1'b1,32'd1,ST_FAULT));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h0,       32'h6,       1'b0,32'h0000000F,32'h0,       32'h4,       1'b1,32'd1,ST_FAULT));
      vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,       32'h6,       1'b0,32'h0000000F,32'h0,       32'h4,       1'b1,32'd1,ST_FAULT));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'h6,       1'b0,32'h0000000F,32'h0,       32'h4,       1'b1,32'd1,ST_FAULT));
      vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,       32'h0,       1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_IDLE));
      // redirect honoured in IDLE, aligned then misaligned
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h8,       32'h8,       1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_RUN));
      vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,       32'hC,       1'b1,32'h00000F00,32'h8,       32'hC,       1'b0,32'd1,ST_RUN));
      vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,       32'h0,       1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_IDLE));
      vecs.push_back(mk(1'b0,1'b0,1'b1,32'h2,       32'h2,       1'b0,32'h00000013,32'h0,       32'h0,       1'b1,32'd0,ST_FAULT));
      vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,       32'h0,       1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_IDLE));

      // PC wrap from 0xFFFFFFFC to 0
      wvecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,      32'hFFFFFFFC,1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_IDLE));
      wvecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,      32'hFFFFFFFC,1'b0,32'h00000013,32'h0,       32'h0,       1'b0,32'd0,ST_RUN));
      wvecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,      32'h0,       1'b1,32'hF0000000,32'hFFFFFFFC,32'h0,       1'b0,32'd1,ST_RUN));
      wvecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,      32'h4,       1'b1,32'h0000000F,32'h0,       32'h4,       1'b0,32'd2,ST_RUN));

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], 1'b0, i);
      for (int i = 0; i < wvecs.size(); i++)
         run_vec(wvecs[i], 1'b1, 100 + i);

      // final report
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction, its PC and PC+4 toward decode. Supports downstream stall, control-flow redirect with a one-cycle flush bubble, and a sticky misaligned-target fault.

## Interface

- RESET_PC, 32'h00000000, PC loaded on reset; must be 4-byte aligned.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_a  output  32  fetch address to the instruction memory; combinational copy of the PC register.
- imem_rd  input  32  instruction word returned by the instruction memory (combinational, same cycle).
- stall  input  1  decode cannot accept; hold the PC and all registered outputs.
- redirect  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  32  redirect target byte address.
- inst_valid  output  1  inst/inst_pc/pc_plus4 hold a real fetched instruction.
- inst  output  32  registered instruction word.
- inst_pc  output  32  address inst was fetched from.
- pc_plus4  output  32  inst_pc + 4, modulo 2^32.
- misalign_fault  output  1  sticky; redirect target had redirect_pc[1:0] != 0.
- fetch_count  output  32  count of instructions delivered (inst_valid rising into a new word), wraps.

## Operation

- States: IDLE, RUN, FAULT. Reset -> IDLE.
- Reset values: pc = RESET_PC, inst_valid = 0, inst = 32'h00000013 (NOP), inst_pc = 0, pc_plus4 = 0, misalign_fault = 0, fetch_count = 0.
- IDLE: one settle cycle; no capture, inst_valid = 0, pc held. Next state RUN. A redirect in IDLE is honoured (pc <= redirect_pc, or FAULT if misaligned).
- RUN, priority per edge: redirect > stall > advance.
  - redirect, redirect_pc[1:0] == 0: pc <= redirect_pc; inst_valid <= 0 (flush the in-flight word); inst/inst_pc/pc_plus4 hold.
  - redirect, redirect_pc[1:0] != 0: -> FAULT; misalign_fault <= 1; inst_valid <= 0; pc <= redirect_pc (for debug visibility).
  - stall (no redirect): pc, inst, inst_pc, pc_plus4, inst_valid, fetch_count all hold.
  - advance: inst <= imem_rd; inst_pc <= pc; pc_plus4 <= pc + 4; inst_valid <= 1; pc <= pc + 4; fetch_count <= fetch_count + 1.
- FAULT: all outputs frozen, inst_valid = 0, redirect and stall ignored; only reset exits.
- Arithmetic: all PC adds 32-bit, carry discarded; 32'hFFFFFFFC + 4 = 0. fetch_count wraps 32'hFFFFFFFF -> 0.
- No address range check; imem_a bits [1:0] are always 0 in RUN.

## Timing

- imem_a changes only on clk edges (register output); imem_rd sampled at the next edge.
- Fetch latency: address presented in cycle N -> inst valid from edge ending cycle N.
- Redirect penalty: exactly one cycle of inst_valid = 0; target instruction valid on the second edge after redirect is sampled.
- Reset asserted in any state, including mid-stall or FAULT, forces reset values on that edge.
- Decode consumes inst on any edge where inst_valid = 1 and stall = 0.

## Test plan

- Boot: RESET_PC=0, memory words 0x0000000F, 0x000000F0, ... ; release reset -> 1 cycle inst_valid=0, imem_a=0; then inst=0x0000000F/inst_pc=0/pc_plus4=4, next inst=0x000000F0/inst_pc=4, fetch_count 1, 2.
- Stall: assert stall 3 cycles while inst_pc=8 -> inst=0x00000F00, imem_a=0xC, fetch_count all unchanged; release -> inst=0x0000F000, inst_pc=0xC.
- Redirect+stall together to 0x10 -> next edge imem_a=0x10, inst_valid=0; following edge (stall low) inst=0x000F0000, inst_pc=0x10.
- Misaligned redirect to 0x6 -> misalign_fault=1, inst_valid=0; later aligned redirect to 0x0 ignored; reset -> misalign_fault=0, imem_a=RESET_PC.
- Wrap: RESET_PC=0xFFFFFFFC -> first delivered inst_pc=0xFFFFFFFC, pc_plus4=0, next imem_a=0.
- Reset mid-operation during stall with inst_valid=1 -> next edge inst_valid=0, inst=0x00000013, fetch_count=0, state IDLE.
